// File: rtl/vip_chimera_uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM and a small
// receive FIFO presented as a valid/ready byte stream.
module vip_chimera_uart_rx #(
   parameter int ClkPerBit = 16,
   parameter int FifoDepth = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       uart_rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   input  logic       ready_i,
   output logic       frame_err_o,
   output logic       overflow_o,
   output logic       busy_o
);

   localparam int CntW = $clog2(ClkPerBit);
   localparam int PtrW = $clog2(FifoDepth);
   localparam logic [CntW-1:0] HalfLoad = CntW'(ClkPerBit / 2 - 1);
   localparam logic [CntW-1:0] FullLoad = CntW'(ClkPerBit - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      WAIT_IDLE
   } state_t;

   state_t          state_reg, state_next;
   logic [CntW-1:0] cnt_reg, cnt_next;
   logic [2:0]      idx_reg, idx_next;
   logic [7:0]      shreg_reg, shreg_next;
   logic [1:0]      sync_reg;
   logic            rx_s;
   logic            push_req;
   logic            frame_err_next;
   logic            frame_err_reg;
   logic            overflow_reg;

   logic [7:0]      fifo_mem [FifoDepth];
   logic [PtrW:0]   wr_ptr_reg, rd_ptr_reg;
   logic            fifo_empty, fifo_full, pop, push_ok, overflow_next;

   // Line idles high, so the synchroniser resets to 1 to avoid a false start bit.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], uart_rx_i};
      end
   end

   assign rx_s = sync_reg[1];

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         idx_reg       <= '0;
         shreg_reg     <= '0;
         frame_err_reg <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         idx_reg       <= idx_next;
         shreg_reg     <= shreg_next;
         frame_err_reg <= frame_err_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      idx_next       = idx_reg;
      shreg_next     = shreg_reg;
      push_req       = 1'b0;
      frame_err_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               cnt_next   = HalfLoad;
            end
         end
         START: begin
            if (cnt_reg == '0) begin
               if (!rx_s) begin
                  state_next = DATA;
                  cnt_next   = FullLoad;
                  idx_next   = '0;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         DATA: begin
            if (cnt_reg == '0) begin
               shreg_next = {rx_s, shreg_reg[7:1]};
               cnt_next   = FullLoad;
               if (idx_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         STOP: begin
            if (cnt_reg == '0) begin
               if (rx_s) begin
                  push_req   = 1'b1;
                  state_next = IDLE;
               end else begin
                  frame_err_next = 1'b1;
                  state_next     = WAIT_IDLE;
               end
            end else begin
               cnt_next = cnt_reg - 1'b1;
            end
         end
         WAIT_IDLE: begin
            // A held break must not look like a fresh start bit.
            if (rx_s) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
   assign fifo_full  = (wr_ptr_reg[PtrW] != rd_ptr_reg[PtrW]) &&
                       (wr_ptr_reg[PtrW-1:0] == rd_ptr_reg[PtrW-1:0]);
   assign pop           = !fifo_empty && ready_i;
   // A simultaneous pop frees a slot, so a full FIFO can still take the byte.
   assign push_ok       = push_req && (!fifo_full || pop);
   assign overflow_next = push_req && !push_ok;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         overflow_reg <= 1'b0;
      end else begin
         overflow_reg <= overflow_next;
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok && !rst_i) begin
         fifo_mem[wr_ptr_reg[PtrW-1:0]] <= shreg_reg;
      end
   end

   assign data_o      = fifo_empty ? 8'h00 : fifo_mem[rd_ptr_reg[PtrW-1:0]];
   assign valid_o     = !fifo_empty;
   assign frame_err_o = frame_err_reg;
   assign overflow_o  = overflow_reg;
   assign busy_o      = (state_reg != IDLE);

endmodule

// File: tb/tb_vip_chimera_uart_rx.sv
// Bench for vip_chimera_uart_rx: table of frames plus hand-written corner
// sequences; received bytes are scored against an expected-byte queue.
module tb_vip_chimera_uart_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic       uart_rx;
   logic       ready;
   logic [7:0] data;
   logic       valid;
   logic       ferr;
   logic       ovf;
   logic       busy;

   always #5 clk = ~clk;

   vip_chimera_uart_rx #(
      .ClkPerBit(CPB),
      .FifoDepth(4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .uart_rx_i  (uart_rx),
      .data_o     (data),
      .valid_o    (valid),
      .ready_i    (ready),
      .frame_err_o(ferr),
      .overflow_o (ovf),
      .busy_o     (busy)
   );

   typedef struct packed {
      logic [7:0] byte_val;
      logic       stop_bit;
      logic       exp_byte;
   } vec_t;

   vec_t       vecs [6];
   int         n_checks = 0;
   int         n_fail   = 0;
   int         ferr_cnt = 0;
   int         ovf_cnt  = 0;
   logic [7:0] exp_q [$];

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endfunction

   // Scoreboard monitor: every accepted beat must match the queue head.
   always @(negedge clk) begin
      if (!rst) begin
         if (ferr) ferr_cnt++;
         if (ovf) ovf_cnt++;
         if (ferr || ovf) check("err_ovf_exclusive", int'(ferr && ovf), 0);
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_byte: got 0x%0h, none expected", data);
            end else begin
               check("rx_byte", int'(data), int'(exp_q.pop_front()));
            end
         end
      end
   end

   task automatic send_frame(input logic [7:0] b, input logic stop);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stop;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic idle(input int n);
      uart_rx = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   // ready changes just after a rising edge so the monitor sees a stable value.
   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 ready = v;
      @(negedge clk);
   endtask

   task automatic wait_drain(input string name, input int budget);
      for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
      check(name, exp_q.size(), 0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_data"}, int'(data), 0);
      check({tag, "_valid"}, int'(valid), 0);
      check({tag, "_ferr"}, int'(ferr), 0);
      check({tag, "_ovf"}, int'(ovf), 0);
      check({tag, "_busy"}, int'(busy), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int busy_cyc;
      int f0;
      int o0;

      vecs[0] = '{8'h3C, 1'b0, 1'b0};
      vecs[1] = '{8'h55, 1'b1, 1'b1};
      vecs[2] = '{8'h00, 1'b1, 1'b1};
      vecs[3] = '{8'hFF, 1'b1, 1'b1};
      vecs[4] = '{8'h80, 1'b0, 1'b0};
      vecs[5] = '{8'h6B, 1'b1, 1'b1};

      rst     = 1'b1;
      uart_rx = 1'b1;
      ready   = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      idle(4);

      // Single good frame with latency bound from the line falling edge.
      exp_q.push_back(8'hA5);
      fork
         send_frame(8'hA5, 1'b1);
         begin
            lat = 0;
            do begin
               @(negedge clk);
               lat++;
            end while (!valid && lat < 200);
         end
      join
      check("t1_latency_le_156", int'(lat <= 156), 1);
      idle(16);
      wait_drain("t1_drained", 20);
      check("t1_no_ferr", ferr_cnt, 0);
      check("t1_no_ovf", ovf_cnt, 0);

      // Short low glitch is rejected in START.
      busy_cyc = 0;
      uart_rx  = 1'b0;
      for (int i = 0; i < 34; i++) begin
         @(negedge clk);
         if (i == 3) uart_rx = 1'b1;
         if (busy) busy_cyc++;
      end
      check("t2_busy_window", int'(busy_cyc >= 1 && busy_cyc <= 10), 1);
      check("t2_busy_end", int'(busy), 0);
      check("t2_no_ferr", ferr_cnt, 0);

      // Table of frames, good and bad stop bits.
      for (int v = 0; v < 6; v++) begin
         f0 = ferr_cnt;
         if (vecs[v].exp_byte) exp_q.push_back(vecs[v].byte_val);
         send_frame(vecs[v].byte_val, vecs[v].stop_bit);
         idle(2 * CPB);
         wait_drain("vec_drained", 20);
         check("vec_ferr_pulses", ferr_cnt - f0, vecs[v].exp_byte ? 0 : 1);
      end

      // Back-to-back into a stalled FIFO: fifth byte overflows.
      set_ready(1'b0);
      o0 = ovf_cnt;
      for (int b = 1; b <= 5; b++) begin
         if (b <= 4) exp_q.push_back(8'(b));
         send_frame(8'(b), 1'b1);
      end
      idle(16);
      check("t4_ovf_pulses", ovf_cnt - o0, 1);
      check("t4_head_stable", int'(data), 1);
      set_ready(1'b1);
      wait_drain("t4_drained", 20);
      check("t4_valid_low", int'(valid), 0);

      // Full FIFO, pop in the same cycle as the stop-bit accept of 0x77.
      set_ready(1'b0);
      for (int b = 0; b < 4; b++) begin
         exp_q.push_back(8'h10 + 8'(b));
         send_frame(8'h10 + 8'(b), 1'b1);
      end
      idle(8);
      o0 = ovf_cnt;
      exp_q.push_back(8'h77);
      fork
         send_frame(8'h77, 1'b1);
         begin
            repeat (154) @(posedge clk);
            #1 ready = 1'b1;
            @(posedge clk);
            #1 ready = 1'b0;
         end
      join
      idle(16);
      check("t5_no_ovf", ovf_cnt - o0, 0);
      check("t5_still_full_valid", int'(valid), 1);
      set_ready(1'b1);
      wait_drain("t5_drained", 20);
      check("t5_valid_low", int'(valid), 0);

      // Reset mid-frame with a byte already queued.
      set_ready(1'b0);
      send_frame(8'h42, 1'b1);
      idle(16);
      check("t6_pre_valid", int'(valid), 1);
      fork
         send_frame(8'hFF, 1'b1);
         begin
            repeat (60) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            check_all_zero("t6_after_rst");
            rst = 1'b0;
         end
      join
      idle(2 * CPB);
      check("t6_busy_idle", int'(busy), 0);
      check("t6_valid_idle", int'(valid), 0);
      set_ready(1'b1);
      exp_q.push_back(8'h81);
      send_frame(8'h81, 1'b1);
      idle(2 * CPB);
      wait_drain("t6_drained", 20);
      idle(20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
